// File: rtl/ising_run_ctrl_pkg.sv
// Shared types and size helpers for the annealing run controller.
// Every file that needs the FSM encoding or the coupling-table geometry imports this package.
package ising_run_ctrl_pkg;

    localparam int N_DEF             = 3;
    localparam int NUM_WEIGHTS_DEF   = 5;
    localparam int RESET_CYCLES_DEF  = 16;
    localparam int SAMPLE_CYCLES_DEF = 256;
    localparam int CNT_W_DEF         = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One coupling register per unordered oscillator pair.
    function automatic int num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    function automatic int wbits(input int num_weights);
        return (num_weights > 1) ? $clog2(num_weights) : 1;
    endfunction

    function automatic int addr_bits(input int n);
        return (num_pairs(n) > 1) ? $clog2(num_pairs(n)) : 1;
    endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Host-side configuration and run-control bundle of the annealing run controller.
// The host drives it through the master modport; the controller uses the slave modport.
interface ising_run_ctrl_if #(
    parameter int N     = 3,
    parameter int AW    = 2,
    parameter int WBITS = 3,
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WBITS-1:0] cfg_wdata;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] run_cycles;
    logic             busy;
    logic             done;
    logic [N-1:0]     spins;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, abort, run_cycles,
        input  busy, done, spins
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, abort, run_cycles,
        output busy, done, spins
    );
endinterface

// File: rtl/ising_run_ctrl_osc_sync.sv
// Two-flop synchronizer bank that brings the free-running oscillator outputs into the clk domain.
module osc_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture; only the second stage is ever observed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/ising_run_ctrl.sv
// Annealing run sequencer: stores pair couplings, holds/releases the oscillator core,
// then votes each oscillator's phase against oscillator 0 over a fixed window to decode spins.
module ising_run_ctrl
    import ising_run_ctrl_pkg::*;
#(
    parameter  int N             = N_DEF,
    parameter  int NUM_WEIGHTS   = NUM_WEIGHTS_DEF,
    parameter  int RESET_CYCLES  = RESET_CYCLES_DEF,
    parameter  int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter  int CNT_W         = CNT_W_DEF,
    localparam int WBITS         = wbits(NUM_WEIGHTS),
    localparam int NP            = num_pairs(N),
    localparam int AW            = addr_bits(N)
) (
    input  logic                clk,
    input  logic                rstn,
    ising_run_ctrl_if.slave     host,
    output logic                core_rstn,
    output logic [WBITS*NP-1:0] core_weights,
    input  logic [N-1:0]        osc_in
);
    localparam int               AGW         = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [AGW-1:0]   AGREE_HALF  = AGW'(SAMPLE_CYCLES / 2);
    localparam logic [AW:0]      NP_LIM      = (AW + 1)'(NP);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] run_len_r, run_len_s;
    logic [AGW-1:0]   agree_r [1:N-1];
    logic [AGW-1:0]   agree_s [1:N-1];
    logic             core_rstn_r, core_rstn_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [N-1:0]     spins_r, spins_s;
    logic [WBITS-1:0] weights_r [NP];
    logic [N-1:0]     osc_sync_s;

    osc_sync #(.W(N)) u_osc_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (osc_in),
        .q    (osc_sync_s)
    );

    // Majority vote against the reference oscillator; a tie decodes as anti-aligned.
    function automatic logic spin_of(input logic [AGW-1:0] agree);
        return (agree > AGREE_HALF) ? 1'b0 : 1'b1;
    endfunction

    // Run sequencing, agreement counting and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        run_len_s   = run_len_r;
        core_rstn_s = core_rstn_r;
        done_s      = 1'b0;
        spins_s     = spins_r;
        for (int i = 1; i < N; i++) begin
            agree_s[i] = (state_r == ST_SAMPLE)
                       ? agree_r[i] + {{(AGW-1){1'b0}}, (osc_sync_s[i] == osc_sync_s[0])}
                       : {AGW{1'b0}};
        end
        if ((state_r != ST_IDLE) && host.abort) begin
            state_s     = ST_IDLE;
            cnt_s       = CNT_ZERO;
            core_rstn_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (host.start) begin
                        state_s     = ST_RESET;
                        cnt_s       = CNT_ZERO;
                        run_len_s   = host.run_cycles;
                        core_rstn_s = 1'b0;
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                ST_RESET: begin
                    if (cnt_r == RESET_LAST) begin
                        state_s     = (run_len_r == CNT_ZERO) ? ST_SAMPLE : ST_RUN;
                        cnt_s       = CNT_ZERO;
                        core_rstn_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == run_len_r - CNT_ONE) begin
                        state_s = ST_SAMPLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_r == SAMPLE_LAST) begin
                        state_s    = ST_DONE;
                        cnt_s      = CNT_ZERO;
                        done_s     = 1'b1;
                        spins_s[0] = 1'b0;
                        // agree_s already holds the final window sample.
                        for (int i = 1; i < N; i++) begin
                            spins_s[i] = spin_of(agree_s[i]);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
                default: begin
                    state_s     = ST_IDLE;
                    cnt_s       = CNT_ZERO;
                    core_rstn_s = 1'b0;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            run_len_r   <= CNT_ZERO;
            core_rstn_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            spins_r     <= {N{1'b0}};
            for (int i = 1; i < N; i++) begin
                agree_r[i] <= {AGW{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            run_len_r   <= run_len_s;
            core_rstn_r <= core_rstn_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            spins_r     <= spins_s;
            for (int i = 1; i < N; i++) begin
                agree_r[i] <= agree_s[i];
            end
        end
    end

    // Coupling table: host writes land only while idle and only to existing pairs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NP; k++) begin
                weights_r[k] <= {WBITS{1'b0}};
            end
        end else if (host.cfg_we && (state_r == ST_IDLE) && ({1'b0, host.cfg_addr} < NP_LIM)) begin
            weights_r[host.cfg_addr] <= host.cfg_wdata;
        end
    end

    // Flatten the coupling table onto the core's weight bus.
    always_comb begin
        core_weights = {(WBITS*NP){1'b0}};
        for (int k = 0; k < NP; k++) begin
            core_weights[k*WBITS +: WBITS] = weights_r[k];
        end
    end

    assign core_rstn  = core_rstn_r;
    assign host.busy  = busy_r;
    assign host.done  = done_r;
    assign host.spins = spins_r;
endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl: expected completions are queued at start and
// matched against each done pulse; timing, abort, config and reset behaviour are checked too.
module tb_ising_run_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic       core_rstn;
    logic [8:0] core_weights;
    logic [2:0] osc_in;
    int         mode;
    logic [31:0] ph;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [2:0] spins;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    ising_run_ctrl_if #(.N(3), .AW(2), .WBITS(3), .CNT_W(16)) hif ();

    ising_run_ctrl #(
        .N(3), .NUM_WEIGHTS(5), .RESET_CYCLES(16), .SAMPLE_CYCLES(256), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .host         (hif.slave),
        .core_rstn    (core_rstn),
        .core_weights (core_weights),
        .osc_in       (osc_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit order {osc2, osc1, osc0}; period-4 square waves.
    function automatic logic [2:0] osc_pattern(input int m, input logic [31:0] p);
        logic [31:0] p1;
        logic        sq, q;
        p1 = p + 32'd1;
        sq = p[1];
        q  = p1[1];
        case (m)
            0:       return {~sq, sq, sq};
            1:       return {q, ~sq, sq};
            default: return {sq, sq, sq};
        endcase
    endfunction

    initial begin : osc_gen
        ph     = 32'd0;
        osc_in = 3'b000;
        forever begin
            @(posedge clk);
            #2;
            ph     = ph + 32'd1;
            osc_in = osc_pattern(mode, ph);
        end
    end

    task automatic cfg_write(input logic [1:0] addr, input logic [2:0] data);
        hif.cfg_we    = 1'b1;
        hif.cfg_addr  = addr;
        hif.cfg_wdata = data;
        @(posedge clk);
        #1;
        hif.cfg_we = 1'b0;
    endtask

    // Called at posedge+1; cycle 0 is the cycle in which start is high.
    task automatic do_run(input string name, input logic [15:0] rc, input int m,
                          input int abort_cyc, input bit we_at_start, input bit poke_sample,
                          input int exp_done, input logic [2:0] exp_spins,
                          input logic [2:0] prev_spins);
        int   fall_cyc  = -1;
        int   first_hi  = -1;
        int   rst_bad   = 0;
        int   done_cnt  = 0;
        int   exp_fall;
        logic rstn_at_fall = 1'bx;
        exp_t e;
        mode = m;
        if (abort_cyc < 0) begin
            e.spins = exp_spins;
            e.cyc   = exp_done;
            sb_q.push_back(e);
        end
        hif.start      = 1'b1;
        hif.run_cycles = rc;
        hif.cfg_we     = we_at_start;
        hif.cfg_addr   = 2'd1;
        hif.cfg_wdata  = 3'd3;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 16 && core_rstn !== 1'b0) rst_bad++;
            if (c >= 1 && first_hi < 0 && core_rstn === 1'b1) first_hi = c;
            if (hif.done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq({name, "_spurious_done"}, 32'(hif.done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq({name, "_done_cycle"}, c, e.cyc);
                    check_eq({name, "_spins"}, 32'(hif.spins), 32'(e.spins));
                end
            end
            if (c >= 1 && hif.busy === 1'b0) begin
                fall_cyc     = c;
                rstn_at_fall = core_rstn;
                break;
            end
            @(posedge clk);
            #1;
            hif.start     = poke_sample && (c + 1 == 200);
            hif.cfg_we    = poke_sample && (c + 1 == 200);
            hif.cfg_wdata = 3'd5;
            hif.abort     = (c + 1 == abort_cyc);
        end
        hif.start  = 1'b0;
        hif.cfg_we = 1'b0;
        hif.abort  = 1'b0;
        exp_fall = (abort_cyc >= 0) ? abort_cyc + 1 : exp_done + 1;
        check_eq({name, "_busy_fall"}, fall_cyc, exp_fall);
        check_eq({name, "_rstn_low_in_reset"}, rst_bad, 0);
        check_eq({name, "_rstn_first_high"}, first_hi, 17);
        check_eq({name, "_rstn_at_idle"}, 32'(rstn_at_fall), (abort_cyc >= 0) ? 32'd0 : 32'd1);
        check_eq({name, "_missing_done"}, sb_q.size(), 0);
        if (abort_cyc >= 0) begin
            check_eq({name, "_done_count"}, done_cnt, 0);
            check_eq({name, "_spins_kept"}, 32'(hif.spins), 32'(prev_spins));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        mode           = 2;
        rstn           = 1'b0;
        hif.cfg_we     = 1'b0;
        hif.cfg_addr   = 2'd0;
        hif.cfg_wdata  = 3'd0;
        hif.start      = 1'b0;
        hif.abort      = 1'b0;
        hif.run_cycles = 16'd0;
        #12;
        check_eq("rst_busy", 32'(hif.busy), 32'd0);
        check_eq("rst_done", 32'(hif.done), 32'd0);
        check_eq("rst_spins", 32'(hif.spins), 32'd0);
        check_eq("rst_core_rstn", 32'(core_rstn), 32'd0);
        check_eq("rst_weights", 32'(core_weights), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        cfg_write(2'd0, 3'd1);
        cfg_write(2'd2, 3'd4);
        cfg_write(2'd3, 3'd7);
        @(negedge clk);
        check_eq("cfg_weights", 32'(core_weights), 32'h101);
        check_eq("idle_core_rstn_first", 32'(core_rstn), 32'd0);
        @(posedge clk);
        #1;

        // Write with start accepted; start/write during SAMPLE ignored.
        do_run("runA", 16'd100, 0, -1, 1'b1, 1'b1, 373, 3'b100, 3'b000);
        check_eq("runA_weights", 32'(core_weights), 32'h119);
        do_run("abortC", 16'd100, 2, 66, 1'b0, 1'b0, 0, 3'b000, 3'b100);
        do_run("runD", 16'd5, 2, -1, 1'b0, 1'b0, 278, 3'b000, 3'b100);
        do_run("runB", 16'd0, 1, -1, 1'b0, 1'b0, 273, 3'b110, 3'b000);
        check_eq("final_weights", 32'(core_weights), 32'h119);

        mode           = 0;
        hif.start      = 1'b1;
        hif.run_cycles = 16'd100;
        @(posedge clk);
        #1;
        hif.start = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("midrun_rst_busy", 32'(hif.busy), 32'd0);
        check_eq("midrun_rst_done", 32'(hif.done), 32'd0);
        check_eq("midrun_rst_spins", 32'(hif.spins), 32'd0);
        check_eq("midrun_rst_core_rstn", 32'(core_rstn), 32'd0);
        check_eq("midrun_rst_weights", 32'(core_weights), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
